// File: rtl/uart_reader.sv
// -----------------------------------------------------------------------------
// uart_reader
//
// Receive-side word assembler for the debugger UART path. When asked to read,
// it pops N = OUT_BUS_SIZE/UART_BUS_SIZE bytes from a first-word-fall-through
// RX FIFO and packs them little-endian (first byte in the LSB slice) into one
// word. The word is published together with a completion level. An optional
// inactivity timeout aborts a request that starves on an empty FIFO.
//
// Ports
//   i_clk           clock, rising edge
//   i_reset         synchronous, active-high reset
//   i_start_rd      request one word; only honoured while idle
//   i_uart_empty    RX FIFO empty flag
//   i_uart_data_rd  RX FIFO head byte, valid while i_uart_empty = 0
//   o_uart_rd       RX FIFO pop strobe, one cycle per byte
//   o_rd_data       last completed word
//   o_rd_end        level: word completed (cleared by the next accepted start)
//   o_timeout       level: last request aborted (cleared by the next start)
// -----------------------------------------------------------------------------
module uart_reader #(
    parameter int UART_BUS_SIZE  = 8,
    parameter int OUT_BUS_SIZE   = 32,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_start_rd,
    input  logic                     i_uart_empty,
    input  logic [UART_BUS_SIZE-1:0] i_uart_data_rd,
    output logic                     o_uart_rd,
    output logic [OUT_BUS_SIZE-1:0]  o_rd_data,
    output logic                     o_rd_end,
    output logic                     o_timeout
);

    localparam int N     = OUT_BUS_SIZE / UART_BUS_SIZE;
    localparam int PTR_W = $clog2(N) + 1;
    localparam int TMO_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    localparam logic [PTR_W-1:0] PTR_FULL  = PTR_W'(N);
    localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT_CYCLES);

    if ((OUT_BUS_SIZE % UART_BUS_SIZE) != 0) begin : g_bad_width
        $error("uart_reader: OUT_BUS_SIZE must be a multiple of UART_BUS_SIZE");
    end

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_WAIT = 2'd1,
        ST_RD      = 2'd2
    } state_t;

    state_t                    state_q,   state_d;
    logic [PTR_W-1:0]          ptr_q,     ptr_d;
    logic [OUT_BUS_SIZE-1:0]   buf_q,     buf_d;
    logic [TMO_W-1:0]          tmo_cnt_q, tmo_cnt_d;
    logic                      uart_rd_q, uart_rd_d;
    logic [OUT_BUS_SIZE-1:0]   rd_data_q, rd_data_d;
    logic                      rd_end_q,  rd_end_d;
    logic                      timeout_q, timeout_d;

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            buf_q     <= '0;
            tmo_cnt_q <= '0;
            uart_rd_q <= 1'b0;
            rd_data_q <= '0;
            rd_end_q  <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            buf_q     <= buf_d;
            tmo_cnt_q <= tmo_cnt_d;
            uart_rd_q <= uart_rd_d;
            rd_data_q <= rd_data_d;
            rd_end_q  <= rd_end_d;
            timeout_q <= timeout_d;
        end
    end

    // Next-state and next-output logic for the read sequencer.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        buf_d     = buf_q;
        tmo_cnt_d = tmo_cnt_q;
        uart_rd_d = 1'b0;
        rd_data_d = rd_data_q;
        rd_end_d  = rd_end_q;
        timeout_d = timeout_q;

        case (state_q)
            ST_IDLE: begin
                if (i_start_rd) begin
                    rd_end_d  = 1'b0;
                    timeout_d = 1'b0;
                    tmo_cnt_d = '0;
                    state_d   = ST_RD_WAIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_RD_WAIT: begin
                // Completion is checked before the FIFO so a waiting byte is
                // never popped once the word is full.
                if (ptr_q == PTR_FULL) begin
                    rd_data_d = buf_q;
                    rd_end_d  = 1'b1;
                    ptr_d     = '0;
                    state_d   = ST_IDLE;
                end else if (!i_uart_empty) begin
                    for (int i = 0; i < N; i++) begin
                        if (ptr_q == PTR_W'(i)) begin
                            buf_d[i*UART_BUS_SIZE +: UART_BUS_SIZE] = i_uart_data_rd;
                        end else begin
                            buf_d[i*UART_BUS_SIZE +: UART_BUS_SIZE] =
                                buf_q[i*UART_BUS_SIZE +: UART_BUS_SIZE];
                        end
                    end
                    uart_rd_d = 1'b1;
                    tmo_cnt_d = '0;
                    state_d   = ST_RD;
                end else if (TIMEOUT_CYCLES != 0) begin
                    // Counts consecutive starved cycles; fires on the limit-th.
                    tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                    if (tmo_cnt_d == TMO_LIMIT) begin
                        timeout_d = 1'b1;
                        ptr_d     = '0;
                        state_d   = ST_IDLE;
                    end else begin
                        state_d = ST_RD_WAIT;
                    end
                end else begin
                    state_d = ST_RD_WAIT;
                end
            end

            ST_RD: begin
                // One dead cycle so the FIFO flag and head byte reflect the pop.
                uart_rd_d = 1'b0;
                ptr_d     = ptr_q + PTR_W'(1);
                state_d   = ST_RD_WAIT;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign o_uart_rd = uart_rd_q;
    assign o_rd_data = rd_data_q;
    assign o_rd_end  = rd_end_q;
    assign o_timeout = timeout_q;

endmodule

// File: doc/uart_reader.md
# uart_reader

Byte-to-word assembler for the debugger's UART receive path. On request it pops `OUT_BUS_SIZE/UART_BUS_SIZE` bytes from the UART RX FIFO and packs them little-endian into one wide word. It then presents the word with a completion flag to the debugger control unit. It is the receive-side counterpart of the debugger's UART write stage and is protected by an optional inactivity timeout.

## Interface
- `UART_BUS_SIZE`, 8: UART byte width.
- `OUT_BUS_SIZE`, 32: assembled word width. Must be an integer multiple of `UART_BUS_SIZE`. `N = OUT_BUS_SIZE/UART_BUS_SIZE`.
- `TIMEOUT_CYCLES`, 0: maximum consecutive empty-FIFO cycles allowed while waiting for a byte. 0 disables the timeout.
- `i_clk`  in  1  clock; all logic is on the rising edge.
- `i_reset`  in  1  reset, synchronous, active-high.
- `i_start_rd`  in  1  request to assemble one word; sampled only in IDLE.
- `i_uart_empty`  in  1  RX FIFO empty flag.
- `i_uart_data_rd`  in  UART_BUS_SIZE  RX FIFO head byte, first-word-fall-through; valid when `i_uart_empty`=0.
- `o_uart_rd`  out  1  RX FIFO pop strobe, one cycle per byte.
- `o_rd_data`  out  OUT_BUS_SIZE  last completed word.
- `o_rd_end`  out  1  level; word completed.
- `o_timeout`  out  1  level; last request aborted by timeout.

## Operation
- Registers:
  - state (2 bits)
  - byte pointer, `$clog2(N)+1` bits
  - assembly buffer, OUT_BUS_SIZE bits
  - timeout counter, `$clog2(TIMEOUT_CYCLES+1)` bits, minimum 1
  - all outputs are registered directly (no combinational outputs).
- States:
  - **IDLE:**
    - On `i_start_rd`=1: clear `o_rd_end` and `o_timeout`, clear the timeout counter, go to RD_WAIT.
    - Otherwise hold.
  - **RD_WAIT:**
    - If pointer == N:
      - copy buffer to `o_rd_data`
      - set `o_rd_end`=1
      - clear pointer
      - go to IDLE.
    - Else if `i_uart_empty`=0:
      - write `i_uart_data_rd` into buffer slice `[ptr*UART_BUS_SIZE +: UART_BUS_SIZE]`
      - set `o_uart_rd`=1
      - clear the timeout counter
      - go to RD.
    - Else, if `TIMEOUT_CYCLES`≠0:
      - increment the timeout counter.
      - When it reaches `TIMEOUT_CYCLES`: set `o_timeout`=1, clear pointer, go to IDLE. `o_rd_end` stays 0 and `o_rd_data` is unchanged.
  - **RD:**
    - `o_uart_rd`=0, pointer +1, go to RD_WAIT.
    - The extra cycle lets the FIFO empty flag and head byte update after the pop.
- Byte 0 (first received) lands in bits `[UART_BUS_SIZE-1:0]`. Byte N-1 lands in the MSB slice.
- `o_rd_data` changes only at completion. Partial words are never visible.
- `i_start_rd` is ignored outside IDLE. Requests are not queued.

## Timing
- Reset values:
  - state IDLE
  - pointer, buffer, counter = 0
  - `o_uart_rd`=0, `o_rd_data`=0, `o_rd_end`=0, `o_timeout`=0.
- Per byte: 2 cycles minimum (RD_WAIT→RD). `o_uart_rd` is high for exactly 1 cycle per byte and never on consecutive cycles.
- Latency with FIFO never empty: `i_start_rd` sampled at edge E0; `o_rd_end` rises after edge E0+2N+1. For N=4 that is 9 cycles.
- `o_rd_end` / `o_timeout` stay high until the edge at which the next `i_start_rd` is accepted.
- FIFO empty mid-word: stall in RD_WAIT with no pop and the pointer held. Resume on the first non-empty cycle.
- Timeout fires on the `TIMEOUT_CYCLES`-th consecutive empty cycle in RD_WAIT. Any accepted byte restarts the count. Bytes already popped are discarded.
- Reset mid-word: at the reset edge all state returns to reset values and buffered bytes are lost. No pop is issued in the cycle after reset.
- `i_uart_empty`=0 in the same cycle as pointer == N: completion takes priority and no pop occurs.

## Test plan
- **Basic word:** N=4, FIFO preloaded with 0x11,0x22,0x33,0x44, pulse `i_start_rd` → exactly 4 single-cycle `o_uart_rd` pulses 2 cycles apart, `o_rd_data`=0x44332211, `o_rd_end` high 9 cycles after start.
- **FIFO underflow stall:** `i_uart_empty`=1 for 5 cycles after byte 1 with `TIMEOUT_CYCLES`=0 → no pop during the stall, pointer held, final word correct, latency +5.
- **Timeout:** `TIMEOUT_CYCLES`=10, only 2 bytes ever supplied → `o_timeout`=1 after 10 empty cycles, `o_rd_end`=0, `o_rd_data` keeps its previous value. The next start clears `o_timeout`.
- **Back-to-back words:** 8 bytes 0x01..0x08, two starts → `o_rd_data`=0x04030201, then 0x08070605. `o_rd_end` drops on the second start edge.
- **Ignored start and reset:** pulse `i_start_rd` mid-word → no effect. Assert `i_reset` after 2 bytes → all outputs 0 next cycle. A new start assembles the following 4 FIFO bytes from slot 0.
